// File: rtl/xbus_arb_pkg.sv
// rtl/xbus_arb_pkg.sv - shared constants and state encoding for the Xbus arbiter
package xbus_arb_pkg;

    // Upper bound on requesters; sizes padded scan vectors and the index field
    localparam int NREQ_MAX = 8;

    // Width of the encoded requester index
    localparam int IDX_W = 3;

    // Width of the settle-delay counter (SETTLE is at most 3)
    localparam int SETTLE_W = 2;

    // Width of the ack watchdog
    localparam int WD_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

    // Round-robin successor of an index, wrapping at nreq-1
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] cur, input int nreq);
        if (cur == IDX_W'(nreq - 1)) begin
            next_idx = '0;
        end else begin
            next_idx = cur + IDX_W'(1);
        end
    endfunction

endpackage

// File: rtl/xbus_arbiter_rr_pick.sv
// rtl/xbus_arbiter_rr_pick.sv - combinational rotating-priority finder (rr_pick)
module rr_pick
    import xbus_arb_pkg::*;
#(
    parameter int NREQ = 4
)
(
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  pick,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W:0] w_pos;
    logic           w_found;

    // Visit positions ptr, ptr+1, ... wrapping at NREQ-1; the first requesting one wins
    always_comb begin
        pick    = '0;
        idx     = '0;
        w_found = 1'b0;
        w_pos   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_pos = {1'b0, ptr} + (IDX_W+1)'(k);
            if (w_pos >= (IDX_W+1)'(NREQ)) begin
                w_pos = w_pos - (IDX_W+1)'(NREQ);
            end
            for (int j = 0; j < NREQ; j++) begin
                if (!w_found && req[j] && (w_pos == (IDX_W+1)'(j))) begin
                    w_found = 1'b1;
                    pick[j] = 1'b1;
                    idx     = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/xbus_arbiter.sv
// rtl/xbus_arbiter.sv - round-robin Xbus grant sequencer with AOI select enables; optional ack watchdog under XBUS_ARB_TIMEOUT_EN
module xbus_arbiter
    import xbus_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int SETTLE  = 1,
    parameter int TMO_CYC = 255
)
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req,
    input  logic              ack,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   sel_n,
    output logic [IDX_W-1:0]  sel_idx,
    output logic              cycle_start,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic              bus_err
);

    localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE);
    localparam logic [WD_W-1:0]     TMO_LAST  = WD_W'(TMO_CYC - 1);

    arb_state_e          r_state;
    logic [IDX_W-1:0]    r_ptr;
    logic [SETTLE_W-1:0] r_cnt;
    logic [NREQ-1:0]     r_grant;
    logic [IDX_W-1:0]    r_sel_idx;
    logic                r_cycle_start;
    logic [NREQ-1:0]     r_done;

    logic [NREQ-1:0]     w_pick;
    logic [IDX_W-1:0]    w_pick_idx;
    logic                w_any_req;
    logic                w_owner_req;

`ifdef XBUS_ARB_TIMEOUT_EN
    logic [WD_W-1:0]     r_wd;
    logic                r_bus_err;
`else
    logic                w_unused_tmo;
    assign w_unused_tmo = ^TMO_LAST;
`endif

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req  (req),
        .ptr  (r_ptr),
        .pick (w_pick),
        .idx  (w_pick_idx)
    );

    assign w_any_req   = |req;
    // The current owner is still asking for the bus
    assign w_owner_req = |(req & r_grant);

    // Arbitration FSM: grant, settle the AOI selects, wait for ack, then rotate priority
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_cnt         <= '0;
            r_grant       <= '0;
            r_sel_idx     <= '0;
            r_cycle_start <= 1'b0;
            r_done        <= '0;
`ifdef XBUS_ARB_TIMEOUT_EN
            r_wd          <= '0;
            r_bus_err     <= 1'b0;
`endif
        end else begin
            r_cycle_start <= 1'b0;
            r_done        <= '0;
`ifdef XBUS_ARB_TIMEOUT_EN
            r_bus_err     <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_grant   <= w_pick;
                        r_sel_idx <= w_pick_idx;
                        r_cnt     <= SETTLE_LD;
                        r_state   <= ST_SETTLE;
                        // With no settle delay the launch pulse coincides with the grant
                        if (SETTLE == 0) begin
                            r_cycle_start <= 1'b1;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (!w_owner_req) begin
                        r_grant   <= '0;
                        r_sel_idx <= '0;
                        r_state   <= ST_IDLE;
                    end else if (r_cnt == '0) begin
                        r_state <= ST_ACTIVE;
`ifdef XBUS_ARB_TIMEOUT_EN
                        r_wd    <= '0;
`endif
                    end else begin
                        r_cnt <= r_cnt - SETTLE_W'(1);
                        // Launch lands in the cycle the counter shows zero
                        if (r_cnt == SETTLE_W'(1)) begin
                            r_cycle_start <= 1'b1;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (ack) begin
                        r_done  <= r_grant;
                        r_state <= ST_RELEASE;
                    end else if (!w_owner_req) begin
                        r_grant   <= '0;
                        r_sel_idx <= '0;
                        r_state   <= ST_IDLE;
                    end
`ifdef XBUS_ARB_TIMEOUT_EN
                    else if (r_wd == TMO_LAST) begin
                        r_done    <= r_grant;
                        r_bus_err <= 1'b1;
                        r_state   <= ST_RELEASE;
                    end else begin
                        r_wd <= r_wd + WD_W'(1);
                    end
`endif
                end
                ST_RELEASE: begin
                    r_grant   <= '0;
                    r_sel_idx <= '0;
                    r_ptr     <= next_idx(r_sel_idx, NREQ);
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_grant   <= '0;
                    r_sel_idx <= '0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant       = r_grant;
    assign sel_n       = ~r_grant;
    assign sel_idx     = r_sel_idx;
    assign cycle_start = r_cycle_start;
    assign done        = r_done;
    assign busy        = |r_grant;
`ifdef XBUS_ARB_TIMEOUT_EN
    assign bus_err     = r_bus_err;
`else
    assign bus_err     = 1'b0;
`endif

endmodule

// File: tb/tb_xbus_arbiter.sv
// tb/tb_xbus_arbiter.sv - directed self-checking bench for xbus_arbiter
module tb_xbus_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] req1, req2;
    logic       ack1, ack2;
    logic [3:0] grant1, sel_n1, done1, grant2, sel_n2, done2;
    logic [2:0] sel_idx1, sel_idx2;
    logic       cs1, cs2, busy1, busy2, err1, err2;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    xbus_arbiter #(.NREQ(4), .SETTLE(1), .TMO_CYC(10)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .req(req1), .ack(ack1), .grant(grant1), .sel_n(sel_n1),
        .sel_idx(sel_idx1), .cycle_start(cs1), .done(done1), .busy(busy1), .bus_err(err1));

    xbus_arbiter #(.NREQ(4), .SETTLE(2), .TMO_CYC(10)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .req(req2), .ack(ack2), .grant(grant2), .sel_n(sel_n2),
        .sel_idx(sel_idx2), .cycle_start(cs2), .done(done2), .busy(busy2), .bus_err(err2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req1 = 4'b1111; req2 = 4'b0000; ack1 = 1'b0; ack2 = 1'b0;
        tick(); tick(); tick();
        n_tests++; if (grant1 !== 4'b0000) begin n_fail++; $display("FAIL reset_grant got=%b exp=0000", grant1); end
        n_tests++; if (sel_n1 !== 4'b1111) begin n_fail++; $display("FAIL reset_sel_n got=%b exp=1111", sel_n1); end
        n_tests++; if (busy1 !== 1'b0 || cs1 !== 1'b0 || err1 !== 1'b0) begin n_fail++; $display("FAIL reset_flags busy=%b cs=%b err=%b exp=000", busy1, cs1, err1); end
        n_tests++; if (sel_idx1 !== 3'd0 || done1 !== 4'b0000) begin n_fail++; $display("FAIL reset_idx_done idx=%0d done=%b exp=0/0000", sel_idx1, done1); end
        reset_n = 1'b1;
        tick();
        n_tests++; if (grant1 !== 4'b0001 || sel_n1 !== 4'b1110) begin n_fail++; $display("FAIL release_grant grant=%b sel_n=%b exp=0001/1110", grant1, sel_n1); end
        n_tests++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL release_busy got=%b exp=1", busy1); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        for (int i = 0; i < 5; i++) begin
            exp = 4'b0001 << (i % 4);
            n_tests++; if (grant1 !== exp || sel_n1 !== ~exp) begin n_fail++; $display("FAIL rr_grant[%0d] grant=%b sel_n=%b exp=%b", i, grant1, sel_n1, exp); end
            n_tests++; if (sel_idx1 !== 3'(i % 4) || cs1 !== 1'b0) begin n_fail++; $display("FAIL rr_idx[%0d] idx=%0d cs=%b exp=%0d/0", i, sel_idx1, cs1, i % 4); end
            tick();
            n_tests++; if (cs1 !== 1'b1) begin n_fail++; $display("FAIL rr_cs[%0d] got=%b exp=1", i, cs1); end
            tick();
            n_tests++; if (cs1 !== 1'b0) begin n_fail++; $display("FAIL rr_cs_pulse[%0d] got=%b exp=0", i, cs1); end
            tick();
            ack1 = 1'b1;
            tick();
            ack1 = 1'b0;
            n_tests++; if (done1 !== exp) begin n_fail++; $display("FAIL rr_done[%0d] got=%b exp=%b", i, done1, exp); end
            if (i == 4) req1 = 4'b0000;
            tick();
            n_tests++; if (grant1 !== 4'b0000 || done1 !== 4'b0000) begin n_fail++; $display("FAIL rr_dead[%0d] grant=%b done=%b exp=0000", i, grant1, done1); end
            if (i < 4) tick();
        end
    endtask

    task automatic test_latency();
        req2 = 4'b0100;
        tick();
        n_tests++; if (grant2 !== 4'b0100 || sel_n2 !== 4'b1011 || sel_idx2 !== 3'd2) begin n_fail++; $display("FAIL lat_grant grant=%b sel_n=%b idx=%0d exp=0100/1011/2", grant2, sel_n2, sel_idx2); end
        n_tests++; if (cs2 !== 1'b0 || busy2 !== 1'b1) begin n_fail++; $display("FAIL lat_cs0 cs=%b busy=%b exp=0/1", cs2, busy2); end
        tick();
        n_tests++; if (cs2 !== 1'b0) begin n_fail++; $display("FAIL lat_cs1 got=%b exp=0", cs2); end
        tick();
        n_tests++; if (cs2 !== 1'b1) begin n_fail++; $display("FAIL lat_cs2 got=%b exp=1", cs2); end
        tick();
        n_tests++; if (cs2 !== 1'b0) begin n_fail++; $display("FAIL lat_cs3 got=%b exp=0", cs2); end
        ack2 = 1'b1;
        tick();
        ack2 = 1'b0; req2 = 4'b0000;
        n_tests++; if (done2 !== 4'b0100) begin n_fail++; $display("FAIL lat_done got=%b exp=0100", done2); end
        tick();
        n_tests++; if (grant2 !== 4'b0000 || done2 !== 4'b0000 || busy2 !== 1'b0) begin n_fail++; $display("FAIL lat_end grant=%b done=%b busy=%b exp=0000/0000/0", grant2, done2, busy2); end
    endtask

    task automatic test_abort();
        req1 = 4'b0010;
        tick();
        n_tests++; if (grant1 !== 4'b0010) begin n_fail++; $display("FAIL abort_grant got=%b exp=0010", grant1); end
        tick(); tick();
        req1 = 4'b0000;
        tick();
        n_tests++; if (grant1 !== 4'b0000 || done1 !== 4'b0000) begin n_fail++; $display("FAIL abort_active grant=%b done=%b exp=0000/0000", grant1, done1); end
        req1 = 4'b0110;
        tick();
        n_tests++; if (grant1 !== 4'b0010) begin n_fail++; $display("FAIL abort_ptr got=%b exp=0010", grant1); end
        req1 = 4'b0000;
        tick();
        n_tests++; if (grant1 !== 4'b0000 || cs1 !== 1'b0 || done1 !== 4'b0000) begin n_fail++; $display("FAIL abort_settle grant=%b cs=%b done=%b exp=0000/0/0000", grant1, cs1, done1); end
    endtask

    task automatic test_stray_ack();
        ack1 = 1'b1;
        tick();
        n_tests++; if (done1 !== 4'b0000 || grant1 !== 4'b0000 || busy1 !== 1'b0) begin n_fail++; $display("FAIL stray_idle done=%b grant=%b busy=%b exp=0000/0000/0", done1, grant1, busy1); end
        ack1 = 1'b0; req1 = 4'b0001;
        tick();
        n_tests++; if (grant1 !== 4'b0001) begin n_fail++; $display("FAIL stray_grant got=%b exp=0001", grant1); end
        ack1 = 1'b1;
        tick();
        ack1 = 1'b0;
        n_tests++; if (done1 !== 4'b0000 || cs1 !== 1'b1) begin n_fail++; $display("FAIL stray_settle done=%b cs=%b exp=0000/1", done1, cs1); end
        tick();
        n_tests++; if (grant1 !== 4'b0001 || done1 !== 4'b0000) begin n_fail++; $display("FAIL stray_active grant=%b done=%b exp=0001/0000", grant1, done1); end
        ack1 = 1'b1; req1 = 4'b0000;
        tick();
        ack1 = 1'b0;
        n_tests++; if (done1 !== 4'b0001) begin n_fail++; $display("FAIL ack_wins_done got=%b exp=0001", done1); end
        tick();
        n_tests++; if (grant1 !== 4'b0000 || done1 !== 4'b0000) begin n_fail++; $display("FAIL ack_wins_end grant=%b done=%b exp=0000/0000", grant1, done1); end
    endtask

    task automatic test_timeout();
        logic bad;
        req1 = 4'b0011;
        tick();
        n_tests++; if (grant1 !== 4'b0010) begin n_fail++; $display("FAIL tmo_grant got=%b exp=0010", grant1); end
        tick(); tick();
`ifdef XBUS_ARB_TIMEOUT_EN
        bad = 1'b0;
        for (int k = 1; k < 10; k++) begin
            tick();
            if (err1 !== 1'b0 || done1 !== 4'b0000) bad = 1'b1;
        end
        n_tests++; if (bad !== 1'b0) begin n_fail++; $display("FAIL tmo_early got=%b exp=0", bad); end
        tick();
        n_tests++; if (err1 !== 1'b1 || done1 !== 4'b0010) begin n_fail++; $display("FAIL tmo_fire err=%b done=%b exp=1/0010", err1, done1); end
        tick();
        n_tests++; if (err1 !== 1'b0 || grant1 !== 4'b0000) begin n_fail++; $display("FAIL tmo_release err=%b grant=%b exp=0/0000", err1, grant1); end
        tick();
        n_tests++; if (grant1 !== 4'b0001) begin n_fail++; $display("FAIL tmo_next got=%b exp=0001", grant1); end
`else
        bad = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (err1 !== 1'b0) bad = 1'b1;
        end
        n_tests++; if (bad !== 1'b0) begin n_fail++; $display("FAIL notmo_err got=%b exp=0", bad); end
        n_tests++; if (grant1 !== 4'b0010 || done1 !== 4'b0000) begin n_fail++; $display("FAIL notmo_hold grant=%b done=%b exp=0010/0000", grant1, done1); end
`endif
        req1 = 4'b0000;
        tick();
        n_tests++; if (grant1 !== 4'b0000) begin n_fail++; $display("FAIL tmo_cleanup got=%b exp=0000", grant1); end
    endtask

    task automatic test_async_reset();
        req1 = 4'b0100;
        tick();
        n_tests++; if (grant1 !== 4'b0100) begin n_fail++; $display("FAIL arst_grant got=%b exp=0100", grant1); end
        #2 reset_n = 1'b0;
        #1;
        n_tests++; if (grant1 !== 4'b0000 || sel_n1 !== 4'b1111 || busy1 !== 1'b0) begin n_fail++; $display("FAIL arst_drop grant=%b sel_n=%b busy=%b exp=0000/1111/0", grant1, sel_n1, busy1); end
        req1 = 4'b0000;
        #1 reset_n = 1'b1;
        tick();
        n_tests++; if (grant1 !== 4'b0000 || done1 !== 4'b0000) begin n_fail++; $display("FAIL arst_after grant=%b done=%b exp=0000/0000", grant1, done1); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_latency();
        test_abort();
        test_stray_ack();
        test_timeout();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
